// File: rtl/stream_bus_bridge_irq.sv
// Stream-to-bus bridge for the audio output path.
// A DEPTH-entry FIFO is filled from a valid/ready producer and drained by CPU
// reads of the DATA register. Status, control, drop counter and a fill-level
// interrupt are exposed on a 4-register chipselect/read/write bus.
module stream_bus_bridge_irq #(
    parameter int DATA_SIZE      = 28,
    parameter int DEPTH          = 64,
    parameter int THRESH_DEFAULT = DEPTH / 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 chipselect_i,
    input  logic [1:0]           address_i,
    input  logic                 read_i,
    input  logic                 write_i,
    input  logic [31:0]          write_data_i,
    output logic [31:0]          read_data_o,
    input  logic                 source_valid_i,
    input  logic [DATA_SIZE-1:0] source_data_i,
    output logic                 source_ready_o,
    output logic                 irq_o
);

    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [15:0]   DEPTH16 = 16'(DEPTH);
    localparam logic [15:0]   THR_RST = 16'(THRESH_DEFAULT);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]   count_q, count_d;
    logic [15:0]   thresh_q, thresh_d;
    logic [15:0]   drops_q, drops_d;
    logic          irq_en_q, irq_en_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          irq_q, irq_d;
    logic [31:0]   rdata_q, rdata_d;

    logic rd_acc, wr_acc, empty, full;
    logic flush, push, pop, drop, underflow;

    assign rd_acc    = chipselect_i && read_i;
    assign wr_acc    = chipselect_i && write_i;
    assign empty     = (count_q == 16'd0);
    assign full      = (count_q == DEPTH16);
    // Ready depends only on the registered count, so a same-cycle pop on a
    // full FIFO cannot open space for the push.
    assign source_ready_o = !full;

    assign flush     = wr_acc && (address_i == 2'd2) && write_data_i[17];
    assign push      = source_valid_i && !full && !flush;
    // A full-FIFO push attempt during a flush is discarded silently.
    assign drop      = source_valid_i && full && !flush;
    assign pop       = rd_acc && (address_i == 2'd0) && !empty;
    assign underflow = rd_acc && (address_i == 2'd0) && empty;

    // Next-state for pointers, count, flags, config, drops, irq and read data.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        thresh_d = thresh_q;
        irq_en_d = irq_en_q;
        drops_d  = drops_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        rdata_d  = rdata_q;

        if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 16'd1;
            2'b01:   count_d = count_q - 16'd1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 16'd0;
        end

        if (wr_acc && address_i == 2'd2) begin
            thresh_d = write_data_i[15:0];
            irq_en_d = write_data_i[16];
        end

        // Clears are applied first so a same-cycle set wins.
        if (wr_acc && address_i == 2'd1 && write_data_i[18]) ovf_d = 1'b0;
        if (wr_acc && address_i == 2'd1 && write_data_i[19]) udf_d = 1'b0;
        if (drop)      ovf_d = 1'b1;
        if (underflow) udf_d = 1'b1;

        if (wr_acc && address_i == 2'd3) drops_d = 16'd0;
        if (drop && drops_d != 16'hFFFF) drops_d = drops_d + 16'd1;

        if (rd_acc) begin
            case (address_i)
                2'd0:    rdata_d = empty ? 32'd0 : 32'(mem[rd_ptr_q]);
                2'd1:    rdata_d = {11'd0, irq_q, udf_q, ovf_q, full, empty, count_q};
                2'd2:    rdata_d = {15'd0, irq_en_q, thresh_q};
                default: rdata_d = {16'd0, drops_q};
            endcase
        end

        irq_d = irq_en_d && (thresh_d != 16'd0) && (count_d >= thresh_d);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 16'd0;
            thresh_q <= THR_RST;
            irq_en_q <= 1'b0;
            drops_q  <= 16'd0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            thresh_q <= thresh_d;
            irq_en_q <= irq_en_d;
            drops_q  <= drops_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= source_data_i;
    end

    assign read_data_o = rdata_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_stream_bus_bridge_irq.sv
// Bench for stream_bus_bridge_irq: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_stream_bus_bridge_irq;

    localparam int DS    = 28;
    localparam int DEPTH = 12;
    localparam int THR0  = DEPTH / 2;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          chipselect_i = 1'b0;
    logic [1:0]    address_i = 2'd0;
    logic          read_i = 1'b0;
    logic          write_i = 1'b0;
    logic [31:0]   write_data_i = 32'd0;
    logic [31:0]   read_data_o;
    logic          source_valid_i = 1'b0;
    logic [DS-1:0] source_data_i = '0;
    logic          source_ready_o;
    logic          irq_o;

    stream_bus_bridge_irq #(.DATA_SIZE(DS), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .chipselect_i(chipselect_i),
        .address_i(address_i), .read_i(read_i), .write_i(write_i),
        .write_data_i(write_data_i), .read_data_o(read_data_o),
        .source_valid_i(source_valid_i), .source_data_i(source_data_i),
        .source_ready_o(source_ready_o), .irq_o(irq_o)
    );

    always #10 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DS-1:0] q[$];
    logic [15:0]   m_thr = 16'(THR0);
    logic          m_en = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;
    logic          m_irq = 1'b0;
    int            m_drops = 0;
    logic [31:0]   m_rd = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        int n = q.size();
        return {11'd0, m_irq, m_udf, m_ovf, (n == DEPTH), (n == 0), 16'(n)};
    endfunction

    // One clock: drive on the falling edge, advance the model, compare after the rising edge.
    task automatic step(input logic rst, input logic cs, input logic rd, input logic wr,
                        input logic [1:0] a, input logic [31:0] wd,
                        input logic sv, input logic [DS-1:0] sd);
        int  n;
        logic ready, fl, pushed, dropped, popped, under;
        @(negedge clk_i);
        reset_i = rst; chipselect_i = cs; read_i = rd; write_i = wr;
        address_i = a; write_data_i = wd; source_valid_i = sv; source_data_i = sd;
        n = q.size();
        if (rst) begin
            q.delete();
            m_thr = 16'(THR0); m_en = 0; m_ovf = 0; m_udf = 0;
            m_drops = 0; m_rd = 0; m_irq = 0;
        end else begin
            ready   = (n != DEPTH);
            fl      = cs && wr && a == 2'd2 && wd[17];
            pushed  = sv && ready && !fl;
            dropped = sv && !ready && !fl;
            popped  = cs && rd && a == 2'd0 && n > 0;
            under   = cs && rd && a == 2'd0 && n == 0;
            if (cs && rd) begin
                case (a)
                    2'd0:    m_rd = (n > 0) ? 32'(q[0]) : 32'd0;
                    2'd1:    m_rd = m_status();
                    2'd2:    m_rd = {15'd0, m_en, m_thr};
                    default: m_rd = 32'(m_drops);
                endcase
            end
            if (fl) q.delete();
            else begin
                if (popped) void'(q.pop_front());
                if (pushed) q.push_back(sd);
            end
            if (cs && wr && a == 2'd1 && wd[18]) m_ovf = 0;
            if (cs && wr && a == 2'd1 && wd[19]) m_udf = 0;
            if (dropped) m_ovf = 1;
            if (under)   m_udf = 1;
            if (cs && wr && a == 2'd3) m_drops = 0;
            if (dropped && m_drops < 65535) m_drops++;
            if (cs && wr && a == 2'd2) begin
                m_thr = wd[15:0];
                m_en  = wd[16];
            end
            m_irq = m_en && m_thr != 0 && q.size() >= int'(m_thr);
        end
        @(posedge clk_i);
        #1;
        chk("read_data", read_data_o, m_rd);
        chk("irq", 32'(irq_o), 32'(m_irq));
        chk("source_ready", 32'(source_ready_o), 32'(q.size() != DEPTH));
    endtask

    task automatic push(input logic [DS-1:0] d);  step(0, 0, 0, 0, 2'd0, 0, 1, d); endtask
    task automatic rdreg(input logic [1:0] a);    step(0, 1, 1, 0, a, 0, 0, 0);    endtask
    task automatic wrreg(input logic [1:0] a, input logic [31:0] d); step(0, 1, 0, 1, a, d, 0, 0); endtask

    initial begin
        // Reset state
        step(1, 0, 0, 0, 2'd0, 0, 0, 0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_ready", 32'(source_ready_o), 32'd1);
        rdreg(2'd1);
        chk("rst_status", read_data_o, 32'h0001_0000);
        rdreg(2'd2);
        chk("rst_control", read_data_o, 32'(THR0));

        // Three samples in, three out
        push(28'h0000001); push(28'h0ABCDEF); push(28'hFFFFFFF);
        rdreg(2'd0); chk("pop0", read_data_o, 32'h0000_0001);
        rdreg(2'd0); chk("pop1", read_data_o, 32'h00AB_CDEF);
        rdreg(2'd0); chk("pop2", read_data_o, 32'h0FFF_FFFF);
        rdreg(2'd1); chk("count_after_pops", read_data_o & 32'hFFFF, 32'd0);

        // Overflow: DEPTH+2 pushes with valid held
        for (int i = 0; i < DEPTH + 2; i++) push(DS'($urandom));
        chk("ready_when_full", 32'(source_ready_o), 32'd0);
        rdreg(2'd1);
        chk("full_bit", 32'(read_data_o[17]), 32'd1);
        chk("ovf_bit", 32'(read_data_o[18]), 32'd1);
        rdreg(2'd3); chk("drops_2", read_data_o, 32'd2);
        wrreg(2'd1, 32'h0004_0000);
        rdreg(2'd1); chk("ovf_cleared", 32'(read_data_o[18]), 32'd0);

        // Full + pop + push: push refused and counted
        step(0, 1, 1, 0, 2'd0, 0, 1, 28'h1234567);
        rdreg(2'd1); chk("full_pop_count", read_data_o & 32'hFFFF, 32'(DEPTH - 1));
        rdreg(2'd3); chk("full_pop_drops", read_data_o, 32'd3);
        for (int i = 0; i < DEPTH - 1; i++) rdreg(2'd0);

        // Empty read with same-cycle push
        step(0, 1, 1, 0, 2'd0, 0, 1, 28'h0000ABC);
        chk("empty_read", read_data_o, 32'd0);
        rdreg(2'd1);
        chk("udf_bit", 32'(read_data_o[19]), 32'd1);
        chk("empty_push_count", read_data_o & 32'hFFFF, 32'd1);
        wrreg(2'd1, 32'h0008_0000);
        rdreg(2'd0); chk("empty_push_data", read_data_o, 32'h0000_0ABC);

        // Threshold interrupt
        wrreg(2'd2, 32'h0001_0004);
        for (int i = 0; i < 3; i++) push(DS'(i));
        chk("irq_below", 32'(irq_o), 32'd0);
        push(28'd3);
        chk("irq_at_4", 32'(irq_o), 32'd1);
        rdreg(2'd0);
        chk("irq_after_pop", 32'(irq_o), 32'd0);
        push(28'd4);
        chk("irq_again", 32'(irq_o), 32'd1);
        wrreg(2'd2, 32'h0000_0004);
        chk("irq_disabled", 32'(irq_o), 32'd0);
        for (int i = 0; i < 4; i++) rdreg(2'd0);

        // Wrap: simultaneous push/pop pairs keep order
        push(DS'($urandom));
        for (int i = 0; i < 3 * DEPTH; i++) step(0, 1, 1, 0, 2'd0, 0, 1, DS'($urandom));
        rdreg(2'd0);

        // Flush with 10 queued
        for (int i = 0; i < 10; i++) push(DS'($urandom));
        wrreg(2'd2, 32'h0002_0000);
        rdreg(2'd1);
        chk("flush_count", read_data_o & 32'hFFFF, 32'd0);
        chk("flush_empty", 32'(read_data_o[16]), 32'd1);
        rdreg(2'd2); chk("flush_bit_reads_0", 32'(read_data_o[17]), 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] wd;
            logic [1:0]  a;
            int          op;
            op = $urandom_range(0, 9);
            a  = 2'($urandom);
            wd = $urandom;
            if (a == 2'd2) begin
                wd[15:0] = 16'($urandom_range(0, DEPTH + 2));
                if ($urandom_range(0, 7) != 0) wd[17] = 1'b0;
            end
            if (op < 4)      step(0, 1, 1, 0, (op < 3) ? 2'd0 : a, 0, $urandom_range(0, 1) == 1, DS'($urandom));
            else if (op < 5) step(0, 1, 0, 1, a, wd, $urandom_range(0, 1) == 1, DS'($urandom));
            else if (op < 6) step(0, 1, 1, 1, a, wd, $urandom_range(0, 1) == 1, DS'($urandom));
            else             step(0, $urandom_range(0, 1) == 1, 0, 0, a, wd, $urandom_range(0, 3) != 0, DS'($urandom));
        end

        // Reset mid-burst
        wrreg(2'd2, 32'h0001_0003);
        for (int i = 0; i < 5; i++) push(DS'($urandom));
        step(1, 0, 0, 0, 2'd0, 0, 1, DS'($urandom));
        chk("midrst_irq", 32'(irq_o), 32'd0);
        rdreg(2'd1); chk("midrst_status", read_data_o, 32'h0001_0000);
        rdreg(2'd2); chk("midrst_control", read_data_o, 32'(THR0));
        rdreg(2'd3); chk("midrst_drops", read_data_o, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
